// File: rtl/cache_pkg.sv
// rtl/cache_pkg.sv - shared types and default geometry for the direct-mapped cache controller
package cache_pkg;

    localparam int DEF_NUM_SETS   = 16;
    localparam int DEF_DATA_WIDTH = 32;
    localparam int DEF_ADDR_WIDTH = 12;
    localparam int DEF_CNT_W      = 16;
    localparam int DEF_IDX_W      = $clog2(DEF_NUM_SETS);
    localparam int DEF_TAG_W      = DEF_ADDR_WIDTH - DEF_IDX_W;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD_SRAM,
        ST_RD_HIT,
        ST_SRAM_WR,
        ST_MEM_WR,
        ST_MEM_RD_REQ,
        ST_MEM_RD_WAIT,
        ST_FILL
    } cache_state_t;

    typedef struct packed {
        logic                      we;
        logic [DEF_ADDR_WIDTH-1:0] addr;
        logic [DEF_DATA_WIDTH-1:0] wdata;
    } cache_req_t;

endpackage

// File: rtl/dc_tag_array.sv
// rtl/dc_tag_array.sv - per-set valid/tag registers with combinational lookup and one write port
module dc_tag_array #(
    parameter int NUM_SETS = 16,
    parameter int IDX_W    = 4,
    parameter int TAG_W    = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [IDX_W-1:0] rd_idx,
    output logic             rd_valid,
    output logic [TAG_W-1:0] rd_tag,
    input  logic             wr_en,
    input  logic [IDX_W-1:0] wr_idx,
    input  logic [TAG_W-1:0] wr_tag
);

    logic [NUM_SETS-1:0] valid_q;
    logic [TAG_W-1:0]    tag_q [NUM_SETS];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
        end else if (wr_en) begin
            valid_q[wr_idx] <= 1'b1;
        end
    end

    // Tags need no reset: a tag is never looked at unless its valid bit is set.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            tag_q[wr_idx] <= wr_tag;
        end
    end

    assign rd_valid = valid_q[rd_idx];
    assign rd_tag   = tag_q[rd_idx];

endmodule

// File: rtl/dm_cache_ctrl.sv
// rtl/dm_cache_ctrl.sv - direct-mapped write-through no-write-allocate cache controller
module dm_cache_ctrl
    import cache_pkg::*;
#(
    parameter  int NUM_SETS   = DEF_NUM_SETS,
    parameter  int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter  int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter  int CNT_W      = DEF_CNT_W,
    localparam int IDX_W      = $clog2(NUM_SETS),
    localparam int TAG_W      = ADDR_WIDTH - IDX_W
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  cpu_req_valid,
    output logic                  cpu_req_ready,
    input  logic                  cpu_req_we,
    input  logic [ADDR_WIDTH-1:0] cpu_req_addr,
    input  logic [DATA_WIDTH-1:0] cpu_req_wdata,
    output logic                  cpu_rsp_valid,
    output logic [DATA_WIDTH-1:0] cpu_rsp_rdata,
    output logic [IDX_W-1:0]      sram_addr,
    output logic                  sram_re,
    output logic                  sram_we,
    output logic [DATA_WIDTH-1:0] sram_data_in,
    input  logic [DATA_WIDTH-1:0] sram_data_out,
    output logic                  mem_req_valid,
    input  logic                  mem_req_ready,
    output logic                  mem_req_we,
    output logic [ADDR_WIDTH-1:0] mem_req_addr,
    output logic [DATA_WIDTH-1:0] mem_req_wdata,
    input  logic                  mem_rsp_valid,
    input  logic [DATA_WIDTH-1:0] mem_rsp_rdata,
    output logic [CNT_W-1:0]      stat_hits,
    output logic [CNT_W-1:0]      stat_misses
);

    cache_state_t          state_q, state_d;
    cache_req_t            req_q;
    logic [DATA_WIDTH-1:0] fill_q;
    logic [DATA_WIDTH-1:0] rsp_rdata_q;
    logic                  rsp_valid_q;
    logic [CNT_W-1:0]      hits_q, misses_q;
    logic                  lk_valid;
    logic [TAG_W-1:0]      lk_tag;
    logic                  lookup_hit;
    logic                  accept;
    logic [IDX_W-1:0]      req_idx;
    logic [TAG_W-1:0]      req_tag;

    assign req_idx = req_q.addr[IDX_W-1:0];
    assign req_tag = req_q.addr[ADDR_WIDTH-1:IDX_W];

    // Tags only change in FILL, never while IDLE, so looking up the incoming
    // address gives the same answer as looking up the latched one a cycle later.
    dc_tag_array #(
        .NUM_SETS (NUM_SETS),
        .IDX_W    (IDX_W),
        .TAG_W    (TAG_W)
    ) u_tags (
        .clk      (clk),
        .rst_n    (rst_n),
        .rd_idx   (cpu_req_addr[IDX_W-1:0]),
        .rd_valid (lk_valid),
        .rd_tag   (lk_tag),
        .wr_en    (state_q == ST_FILL),
        .wr_idx   (req_idx),
        .wr_tag   (req_tag)
    );

    assign lookup_hit = lk_valid && (lk_tag == cpu_req_addr[ADDR_WIDTH-1:IDX_W]);
    assign accept     = cpu_req_valid && cpu_req_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        cpu_req_ready = 1'b0;
        sram_addr     = '0;
        sram_re       = 1'b0;
        sram_we       = 1'b0;
        sram_data_in  = '0;
        mem_req_valid = 1'b0;
        mem_req_we    = 1'b0;
        mem_req_addr  = '0;
        mem_req_wdata = '0;
        case (state_q)
            ST_IDLE: begin
                cpu_req_ready = 1'b1;
                if (accept) begin
                    if (cpu_req_we) state_d = lookup_hit ? ST_SRAM_WR : ST_MEM_WR;
                    else            state_d = lookup_hit ? ST_RD_SRAM : ST_MEM_RD_REQ;
                end
            end
            ST_RD_SRAM: begin
                sram_re   = 1'b1;
                sram_addr = req_idx;
                state_d   = ST_RD_HIT;
            end
            ST_RD_HIT: state_d = ST_IDLE;
            ST_SRAM_WR: begin
                sram_we      = 1'b1;
                sram_addr    = req_idx;
                sram_data_in = req_q.wdata;
                state_d      = ST_MEM_WR;
            end
            ST_MEM_WR: begin
                mem_req_valid = 1'b1;
                mem_req_we    = 1'b1;
                mem_req_addr  = req_q.addr;
                mem_req_wdata = req_q.wdata;
                if (mem_req_ready) state_d = ST_IDLE;
            end
            ST_MEM_RD_REQ: begin
                mem_req_valid = 1'b1;
                mem_req_addr  = req_q.addr;
                if (mem_req_ready) state_d = ST_MEM_RD_WAIT;
            end
            ST_MEM_RD_WAIT: if (mem_rsp_valid) state_d = ST_FILL;
            ST_FILL: begin
                sram_we      = 1'b1;
                sram_addr    = req_idx;
                sram_data_in = fill_q;
                state_d      = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req_q       <= '0;
            fill_q      <= '0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            hits_q      <= '0;
            misses_q    <= '0;
        end else begin
            rsp_valid_q <= 1'b0;
            case (state_q)
                ST_IDLE: if (accept) req_q <= '{we: cpu_req_we, addr: cpu_req_addr, wdata: cpu_req_wdata};
                ST_RD_HIT: begin
                    rsp_valid_q <= 1'b1;
                    rsp_rdata_q <= sram_data_out;
                    if (hits_q != '1) hits_q <= hits_q + 1'b1;
                end
                ST_MEM_WR: if (mem_req_ready) rsp_valid_q <= 1'b1;
                ST_MEM_RD_WAIT: if (mem_rsp_valid) fill_q <= mem_rsp_rdata;
                ST_FILL: begin
                    rsp_valid_q <= 1'b1;
                    rsp_rdata_q <= fill_q;
                    if (misses_q != '1) misses_q <= misses_q + 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign cpu_rsp_valid = rsp_valid_q;
    assign cpu_rsp_rdata = rsp_rdata_q;
    assign stat_hits     = hits_q;
    assign stat_misses   = misses_q;

endmodule

// File: tb/tb_dm_cache_ctrl.sv
// tb/tb_dm_cache_ctrl.sv - directed scoreboard bench for dm_cache_ctrl
module tb_dm_cache_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cpu_req_valid, cpu_req_ready, cpu_req_we;
    logic [11:0] cpu_req_addr;
    logic [31:0] cpu_req_wdata;
    logic        cpu_rsp_valid;
    logic [31:0] cpu_rsp_rdata;
    logic [3:0]  sram_addr;
    logic        sram_re, sram_we;
    logic [31:0] sram_data_in, sram_data_out;
    logic        mem_req_valid, mem_req_ready, mem_req_we;
    logic [11:0] mem_req_addr;
    logic [31:0] mem_req_wdata;
    logic        mem_rsp_valid;
    logic [31:0] mem_rsp_rdata;
    logic [15:0] stat_hits, stat_misses;

    int total = 0;
    int bad = 0;
    int n_txn = 0;
    logic [31:0] sb [$];

    always #5 clk = ~clk;

    dm_cache_ctrl dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .cpu_req_valid (cpu_req_valid),
        .cpu_req_ready (cpu_req_ready),
        .cpu_req_we    (cpu_req_we),
        .cpu_req_addr  (cpu_req_addr),
        .cpu_req_wdata (cpu_req_wdata),
        .cpu_rsp_valid (cpu_rsp_valid),
        .cpu_rsp_rdata (cpu_rsp_rdata),
        .sram_addr     (sram_addr),
        .sram_re       (sram_re),
        .sram_we       (sram_we),
        .sram_data_in  (sram_data_in),
        .sram_data_out (sram_data_out),
        .mem_req_valid (mem_req_valid),
        .mem_req_ready (mem_req_ready),
        .mem_req_we    (mem_req_we),
        .mem_req_addr  (mem_req_addr),
        .mem_req_wdata (mem_req_wdata),
        .mem_rsp_valid (mem_rsp_valid),
        .mem_rsp_rdata (mem_rsp_rdata),
        .stat_hits     (stat_hits),
        .stat_misses   (stat_misses)
    );

    // Single-port sram: read data appears the cycle after sram_re.
    logic [31:0] smem [16];
    always @(posedge clk) begin
        if (sram_we) smem[sram_addr] <= sram_data_in;
        if (sram_re) sram_data_out <= smem[sram_addr];
    end

    // Backing memory: untouched words return a fixed pattern derived from the address.
    logic [31:0] bmem [4096];
    logic        bmem_wr [4096];
    int          rsp_lat = 2;
    logic        pend;
    int          cd;
    logic [11:0] paddr;

    function automatic logic [31:0] init_val(input logic [11:0] a);
        return (a == 12'h005) ? 32'hDEADBEEF : {20'h5A5A5, a};
    endfunction

    function automatic logic [31:0] bmem_rd(input logic [11:0] a);
        return (bmem_wr[a] === 1'b1) ? bmem[a] : init_val(a);
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend          <= 1'b0;
            cd            <= 0;
            paddr         <= '0;
            mem_rsp_valid <= 1'b0;
            mem_rsp_rdata <= '0;
        end else begin
            mem_rsp_valid <= 1'b0;
            if (pend) begin
                if (cd <= 1) begin
                    mem_rsp_valid <= 1'b1;
                    mem_rsp_rdata <= bmem_rd(paddr);
                    pend          <= 1'b0;
                end else begin
                    cd <= cd - 1;
                end
            end
            if (mem_req_valid && mem_req_ready) begin
                if (mem_req_we) begin
                    bmem[mem_req_addr]    <= mem_req_wdata;
                    bmem_wr[mem_req_addr] <= 1'b1;
                end else begin
                    pend  <= 1'b1;
                    cd    <= rsp_lat;
                    paddr <= mem_req_addr;
                end
            end
        end
    end

    int          n_sram_we = 0, n_mem_wr = 0, n_mem_rd = 0, n_rsp = 0, inv_bad = 0;
    logic [3:0]  last_sw_addr;
    logic [31:0] last_sw_data, last_mw_data;
    logic [11:0] last_mw_addr;

    always @(posedge clk) begin
        if (rst_n) begin
            if (sram_we) begin
                n_sram_we    <= n_sram_we + 1;
                last_sw_addr <= sram_addr;
                last_sw_data <= sram_data_in;
            end
            if (mem_req_valid && mem_req_ready) begin
                if (mem_req_we) begin
                    n_mem_wr     <= n_mem_wr + 1;
                    last_mw_addr <= mem_req_addr;
                    last_mw_data <= mem_req_wdata;
                end else begin
                    n_mem_rd <= n_mem_rd + 1;
                end
            end
            if (cpu_rsp_valid) n_rsp <= n_rsp + 1;
        end
    end

    always @(negedge clk) begin
        if ((sram_re && sram_we) ||
            (!sram_re && !sram_we && sram_addr != 4'd0) ||
            (!sram_we && sram_data_in != 32'd0) ||
            (!mem_req_valid && (mem_req_we || mem_req_addr != 12'd0 || mem_req_wdata != 32'd0)))
            inv_bad <= inv_bad + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic do_req(input logic we, input logic [11:0] addr, input logic [31:0] wd,
                          input logic [31:0] exp, output int lat, output logic re_c1,
                          output logic mv_c1);
        int n;
        logic [31:0] e;
        sb.push_back(exp);
        n_txn++;
        @(negedge clk);
        n = 0;
        while (!cpu_req_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        cpu_req_valid = 1'b1;
        cpu_req_we    = we;
        cpu_req_addr  = addr;
        cpu_req_wdata = wd;
        @(posedge clk);
        #1;
        cpu_req_valid = 1'b0;
        cpu_req_we    = ~we;
        cpu_req_addr  = 12'($urandom);
        cpu_req_wdata = $urandom;
        re_c1 = sram_re;
        mv_c1 = mem_req_valid;
        lat = 1;
        while (!cpu_rsp_valid && lat < 300) begin
            @(posedge clk);
            #1;
            lat++;
        end
        chk("rsp_seen", 32'(cpu_rsp_valid), 32'd1);
        e = sb.pop_front();
        chk("rsp_rdata", cpu_rsp_rdata, e);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int   lat, b_we, b_mw, b_mr, m0;
        logic re1, mv1;
        cpu_req_valid = 1'b0;
        cpu_req_we    = 1'b0;
        cpu_req_addr  = '0;
        cpu_req_wdata = '0;
        mem_req_ready = 1'b1;
        rst_n         = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ready", 32'(cpu_req_ready), 32'd1);
        chk("rst_rsp_valid", 32'(cpu_rsp_valid), 32'd0);
        chk("rst_rsp_rdata", cpu_rsp_rdata, 32'd0);
        chk("rst_mem_valid", 32'(mem_req_valid), 32'd0);
        chk("rst_sram_en", 32'({sram_re, sram_we}), 32'd0);
        chk("rst_stats", {stat_hits, stat_misses}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Cold read miss fills idx 5
        b_we = n_sram_we; b_mr = n_mem_rd;
        do_req(1'b0, 12'h005, 32'h0, 32'hDEADBEEF, lat, re1, mv1);
        chk("miss_mem_rd", 32'(n_mem_rd - b_mr), 32'd1);
        chk("miss_sram_we", 32'(n_sram_we - b_we), 32'd1);
        chk("fill_addr", 32'(last_sw_addr), 32'd5);
        chk("fill_data", last_sw_data, 32'hDEADBEEF);
        chk("misses_1", 32'(stat_misses), 32'd1);
        chk("hits_0", 32'(stat_hits), 32'd0);

        // Read hit: three-cycle latency, no memory traffic
        b_mr = n_mem_rd;
        do_req(1'b0, 12'h005, 32'h0, 32'hDEADBEEF, lat, re1, mv1);
        chk("hit_lat", 32'(lat), 32'd3);
        chk("hit_re_c1", 32'(re1), 32'd1);
        chk("hit_no_mem_c1", 32'(mv1), 32'd0);
        chk("hit_mem_rd", 32'(n_mem_rd - b_mr), 32'd0);
        chk("hits_1", 32'(stat_hits), 32'd1);

        // Write hit updates sram and memory; rdata holds previous value
        b_we = n_sram_we; b_mw = n_mem_wr;
        do_req(1'b1, 12'h005, 32'h12345678, 32'hDEADBEEF, lat, re1, mv1);
        chk("wh_sram_we", 32'(n_sram_we - b_we), 32'd1);
        chk("wh_sram_data", last_sw_data, 32'h12345678);
        chk("wh_mem_wr", 32'(n_mem_wr - b_mw), 32'd1);
        chk("wh_mem_addr", 32'(last_mw_addr), 32'h005);
        chk("wh_mem_data", last_mw_data, 32'h12345678);
        chk("wh_hits_unchanged", 32'(stat_hits), 32'd1);
        do_req(1'b0, 12'h005, 32'h0, 32'h12345678, lat, re1, mv1);
        chk("wh_readback_lat", 32'(lat), 32'd3);
        chk("hits_2", 32'(stat_hits), 32'd2);

        // Write miss: memory only, no allocation
        b_we = n_sram_we; b_mw = n_mem_wr; b_mr = n_mem_rd;
        do_req(1'b1, 12'h0A3, 32'hCAFEF00D, 32'h12345678, lat, re1, mv1);
        chk("wm_sram_we", 32'(n_sram_we - b_we), 32'd0);
        chk("wm_mem_wr", 32'(n_mem_wr - b_mw), 32'd1);
        do_req(1'b0, 12'h0A3, 32'h0, 32'hCAFEF00D, lat, re1, mv1);
        chk("wm_read_miss", 32'(n_mem_rd - b_mr), 32'd1);
        chk("misses_2", 32'(stat_misses), 32'd2);

        // Conflicting tags on idx 5
        m0 = stat_misses; b_mr = n_mem_rd;
        do_req(1'b0, 12'h015, 32'h0, init_val(12'h015), lat, re1, mv1);
        do_req(1'b0, 12'h025, 32'h0, init_val(12'h025), lat, re1, mv1);
        do_req(1'b0, 12'h015, 32'h0, init_val(12'h015), lat, re1, mv1);
        chk("conf_misses", 32'(stat_misses - 16'(m0)), 32'd3);
        chk("conf_mem_rd", 32'(n_mem_rd - b_mr), 32'd3);
        b_we = n_sram_we;
        do_req(1'b1, 12'h035, 32'h0BADF00D, init_val(12'h015), lat, re1, mv1);
        chk("conf_wr_no_sram", 32'(n_sram_we - b_we), 32'd0);
        do_req(1'b0, 12'h015, 32'h0, init_val(12'h015), lat, re1, mv1);
        chk("conf_tag_kept_lat", 32'(lat), 32'd3);

        // Stall the request, then reset while waiting for read data
        rsp_lat = 6;
        mem_req_ready = 1'b0;
        @(negedge clk);
        cpu_req_valid = 1'b1;
        cpu_req_we    = 1'b0;
        cpu_req_addr  = 12'h025;
        @(posedge clk);
        #1;
        cpu_req_valid = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        chk("stall_valid", 32'(mem_req_valid), 32'd1);
        chk("stall_addr", 32'(mem_req_addr), 32'h025);
        chk("stall_we", 32'(mem_req_we), 32'd0);
        @(negedge clk);
        mem_req_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("wait_no_req", 32'(mem_req_valid), 32'd0);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_ready", 32'(cpu_req_ready), 32'd1);
        chk("mid_rst_rsp", {31'd0, cpu_rsp_valid}, 32'd0);
        chk("mid_rst_rdata", cpu_rsp_rdata, 32'd0);
        chk("mid_rst_stats", {stat_hits, stat_misses}, 32'd0);
        chk("mid_rst_outs", 32'({mem_req_valid, sram_re, sram_we}), 32'd0);
        @(negedge clk);
        rst_n   = 1'b1;
        rsp_lat = 2;
        b_mr = n_mem_rd;
        do_req(1'b0, 12'h005, 32'h0, 32'h12345678, lat, re1, mv1);
        chk("post_rst_miss", 32'(n_mem_rd - b_mr), 32'd1);
        chk("post_rst_misses", 32'(stat_misses), 32'd1);
        chk("post_rst_hits", 32'(stat_hits), 32'd0);

        repeat (2) @(posedge clk);
        #1;
        chk("rsp_count", 32'(n_rsp), 32'(n_txn));
        chk("invariants", 32'(inv_bad), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
